// File: rtl/palette_writer_pkg.sv
// Shared definitions for the palette writer.
//   RGB_BIT  bits per colour entry
//   NUM_PAL  number of palettes
//   PAL_AW   palette address width
//   ROW_W    width of one packed palette row {c00,c01,c10,c11}
//   state_e  commit FSM encoding
//   slot_lsb helper: LSB position of a colour slot inside a packed row
package palette_writer_pkg;

   localparam int unsigned RGB_BIT = 12;
   localparam int unsigned NUM_PAL = 4;
   localparam int unsigned PAL_AW  = 2;
   localparam int unsigned ROW_W   = 4 * RGB_BIT;

   typedef enum logic [1:0] {
      StIdle,
      StPending,
      StCopy,
      StDone
   } state_e;

   // Slot 0 lives in the MSBs, slot 3 in the LSBs.
   function automatic int unsigned slot_lsb(input logic [1:0] idx);
      return (32'd3 - 32'(idx)) * RGB_BIT;
   endfunction

endpackage

// File: rtl/palette_dirty_scan.sv
// Priority encoder over the dirty-palette mask.
//   dirty   in   NUM_PAL  one bit per palette with uncommitted shadow data
//   lowest  out  PAL_AW   index of the lowest set bit (0 when none set)
//   any     out  1        at least one bit set
module palette_dirty_scan
   import palette_writer_pkg::*;
(
   input  logic [NUM_PAL-1:0] dirty,
   output logic [PAL_AW-1:0]  lowest,
   output logic               any
);

   // Walk from the top down so the last hit is the lowest index.
   always_comb begin
      lowest = '0;
      any    = 1'b0;
      for (int i = NUM_PAL - 1; i >= 0; i--) begin
         if (dirty[i]) begin
            lowest = PAL_AW'(i);
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/palette_writer.sv
// Palette writer: collects CPU colour writes in a shadow palette store and
// copies dirty palette rows into the live palette memory during vblank, so
// the renderer never observes a half-updated palette mid-frame.
//   clk, rst     clock, synchronous active-high reset
//   wr_*         CPU colour-write channel (valid/ready handshake)
//   commit_req   pulse: commit all dirty palettes at the next vblank
//   vblank       level, high during vertical blank
//   busy         commit pending or copying
//   commit_done  one-cycle pulse when a commit finishes
//   pal_we/pal_waddr/pal_wdata  registered live palette memory write port
module palette_writer
   import palette_writer_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [PAL_AW-1:0]    wr_pal,
   input  logic [1:0]           wr_idx,
   input  logic [RGB_BIT-1:0]   wr_color,
   input  logic                 commit_req,
   input  logic                 vblank,
   output logic                 busy,
   output logic                 commit_done,
   output logic                 pal_we,
   output logic [PAL_AW-1:0]    pal_waddr,
   output logic [ROW_W-1:0]     pal_wdata
);

   state_e              state_q;
   logic [NUM_PAL-1:0]  dirty_q;
   logic [NUM_PAL-1:0]  dirty_w;
   logic [ROW_W-1:0]    shadow_q [NUM_PAL];
   logic [ROW_W-1:0]    shadow_w [NUM_PAL];

   logic                wr_ready_q;
   logic                busy_q;
   logic                commit_done_q;
   logic                pal_we_q;
   logic [PAL_AW-1:0]   pal_waddr_q;
   logic [ROW_W-1:0]    pal_wdata_q;

   logic                wr_fire;
   logic [PAL_AW-1:0]   scan_idx;
   logic                scan_any;

   assign wr_fire = wr_valid & wr_ready_q;

   // Shadow/dirty with this cycle's accepted write merged in. The FSM works
   // from these so a write landing on the same edge as a commit decision or
   // the first copy is still included.
   always_comb begin
      shadow_w = shadow_q;
      dirty_w  = dirty_q;
      if (wr_fire) begin
         shadow_w[wr_pal][slot_lsb(wr_idx) +: RGB_BIT] = wr_color;
         dirty_w[wr_pal] = 1'b1;
      end
   end

   palette_dirty_scan u_scan (
      .dirty  (dirty_w),
      .lowest (scan_idx),
      .any    (scan_any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         dirty_q       <= '0;
         for (int i = 0; i < NUM_PAL; i++) begin
            shadow_q[i] <= '0;
         end
         wr_ready_q    <= 1'b1;
         busy_q        <= 1'b0;
         commit_done_q <= 1'b0;
         pal_we_q      <= 1'b0;
         pal_waddr_q   <= '0;
         pal_wdata_q   <= '0;
      end else begin
         shadow_q      <= shadow_w;
         dirty_q       <= dirty_w;
         pal_we_q      <= 1'b0;
         commit_done_q <= 1'b0;

         unique case (state_q)
            StIdle: begin
               if (commit_req) begin
                  if (dirty_w == '0) begin
                     state_q       <= StDone;
                     commit_done_q <= 1'b1;
                  end else begin
                     state_q <= StPending;
                     busy_q  <= 1'b1;
                  end
               end
            end
            StPending: begin
               // The first row goes out on the edge that enters COPY, so
               // pal_we is high for every cycle spent in COPY.
               if (vblank) begin
                  state_q           <= StCopy;
                  wr_ready_q        <= 1'b0;
                  pal_we_q          <= 1'b1;
                  pal_waddr_q       <= scan_idx;
                  pal_wdata_q       <= shadow_w[scan_idx];
                  dirty_q[scan_idx] <= 1'b0;
               end
            end
            StCopy: begin
               // Writes are blocked here, so dirty_w only shrinks.
               if (scan_any) begin
                  pal_we_q          <= 1'b1;
                  pal_waddr_q       <= scan_idx;
                  pal_wdata_q       <= shadow_w[scan_idx];
                  dirty_q[scan_idx] <= 1'b0;
               end else begin
                  state_q       <= StDone;
                  wr_ready_q    <= 1'b1;
                  busy_q        <= 1'b0;
                  commit_done_q <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign wr_ready    = wr_ready_q;
   assign busy        = busy_q;
   assign commit_done = commit_done_q;
   assign pal_we      = pal_we_q;
   assign pal_waddr   = pal_waddr_q;
   assign pal_wdata   = pal_wdata_q;

endmodule

// File: doc/palette_writer.md
Name: palette_writer

Overview:
- Write-side companion to the PPU palette lookup: accepts per-colour writes from the CPU bus into a shadow palette store, then commits changed palettes to the live palette memory during vertical blank.
- Commits happen only in vblank, so the renderer's combinational palette read never sees a half-updated palette mid-frame.
- Sits between the CPU peripheral register interface and the palette memory write port.

Parameters:
- RGB_BIT, 12, bits per colour entry (matches the global `RGB_BIT` define)
- NUM_PAL, 4, number of palettes (PaletteChoice range)
- PAL_AW, 2, palette address width, clog2(NUM_PAL)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- wr_valid  in  1  CPU colour-write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_pal  in  PAL_AW  target palette
- wr_idx  in  2  colour slot (00..11, maps to PaletteColor00..11)
- wr_color  in  RGB_BIT  colour value
- commit_req  in  1  one-cycle pulse: request commit of dirty palettes
- vblank  in  1  level, high during vertical blank
- busy  out  1  commit pending or in progress
- commit_done  out  1  one-cycle pulse when commit completes
- pal_we  out  1  live palette memory write enable
- pal_waddr  out  PAL_AW  live palette row address
- pal_wdata  out  4*RGB_BIT  packed row {c00,c01,c10,c11}; c00 in the MSBs

Behaviour:
- Reset values (synchronous, rst high at posedge): all outputs 0 except wr_ready=1; shadow store all 0; dirty[NUM_PAL-1:0]=0; FSM=IDLE.
- Shadow store: NUM_PAL x 4 x RGB_BIT registers.
- An accepted write updates shadow[wr_pal][wr_idx] and sets dirty[wr_pal] at the same posedge (latency 1).
- FSM states: IDLE, PENDING, COPY, DONE.
- IDLE:
  - commit_req -> PENDING.
  - If dirty==0 at that edge -> DONE directly (commit_done still pulses, no pal_we).
- PENDING:
  - busy=1; wr_ready=1, so writes are still accepted and are included in the commit.
  - vblank high -> COPY; a row pointer latches the lowest set dirty bit.
- COPY:
  - wr_ready=0, busy=1.
  - Each cycle: pal_we=1, pal_waddr=ptr, pal_wdata=shadow[ptr] packed; dirty[ptr] is cleared; ptr advances to the next set dirty bit.
  - When no dirty bits remain -> DONE.
  - Worst case NUM_PAL cycles. COPY does not abort if vblank falls (vblank is guaranteed >= NUM_PAL cycles).
- DONE: commit_done=1 for exactly one cycle, busy=0, wr_ready=1 -> IDLE.
- commit_req while busy: ignored (no queueing); the pending commit already captures all dirty rows.
- Write and commit_req in the same IDLE cycle: the write is accepted and included in the commit.
- Write to an already-dirty palette while PENDING: overwrites the shadow; the row is copied once.
- wr_idx mapping: 0->bits[4R-1:3R], 1->[3R-1:2R], 2->[2R-1:R], 3->[R-1:0], where R=RGB_BIT.
- Reset mid-COPY: FSM->IDLE, dirty and shadow cleared, pal_we=0 on the next cycle. Partially written live rows are left as written.
- pal_we/pal_waddr/pal_wdata are registered outputs.

Decomposition:
- Shared package/define file holds: RGB_BIT, NUM_PAL, PAL_AW, FSM state encoding, slot-to-bit-range helper.
- One natural sub-module, palette_dirty_scan: priority encoder returning the lowest set dirty index plus an any-set flag. Used for both the ptr latch and the ptr advance.

Test Plan:
- Reset: rst high 2 cycles -> wr_ready=1, busy=0, pal_we=0, commit_done=0; a commit with nothing written gives a commit_done pulse and zero pal_we cycles.
- Write pal1 colours 0x111,0x222,0x333,0x444; pulse commit_req with vblank=0 -> busy=1, no pal_we. Raise vblank -> exactly one pal_we, waddr=1, wdata=0x111222333444, then commit_done one cycle later.
- Dirty pal0 and pal3 -> pal_we in consecutive cycles, addr 0 then 3; wr_ready=0 during both; commit_done after.
- In PENDING, write pal2 idx2=0xABC -> included in the COPY; pal2 row has 0xABC at bits[23:12].
- Assert wr_valid during COPY -> wr_ready=0, no shadow change. The write completes after DONE and sets dirty for the next commit.
- Assert rst in the first COPY cycle with 3 dirty rows -> next cycle pal_we=0, busy=0; a later commit with no writes issues no pal_we.
